pipeline_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipelined MIPS core (IF, ID, EX, MEM, WB). It consumes the registered decoder control bits of later stages (reg_wr, mem2reg, branch outcome, jmp) and the data-memory handshake. From these it generates per-stage enable/flush strobes, the PC source select, a bus-error halt, and two performance counters. It replaces ad-hoc stall logic scattered across stage registers.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/hazard_detect.sv | 29 ++
 rtl/pipeline_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush sequencer
package pipe_ctrl_pkg;

  // Sequencer states: normal flow, waiting on data memory, sticky bus-error halt
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  // PC source select encodings
  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;

  // Default register-address width of the core
  localparam int DEF_REG_AW = 5;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard comparator
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_wr_reg,
  input  logic              ex_mem2reg,
  input  logic              ex_reg_wr,
  output logic              load_use
);

  logic ex_is_load;
  logic rs_hit;
  logic rt_hit;

  // A load in EX that writes a real register (r0 is hardwired zero) and
  // whose destination is a source of the ID instruction must stall one cycle.
  always_comb begin
    ex_is_load = ex_mem2reg & ex_reg_wr & (ex_wr_reg != '0);
    rs_hit     = (ex_wr_reg == id_rs);
    rt_hit     = id_uses_rt & (ex_wr_reg == id_rt);
    load_use   = ex_is_load & (rs_hit | rt_hit);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - central stall/flush sequencer for the 5-stage pipeline
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW  = DEF_REG_AW,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_jmp,
  input  logic              ex_reg_wr,
  input  logic              ex_mem2reg,
  input  logic [REG_AW-1:0] ex_wr_reg,
  input  logic              ex_br_taken,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [1:0]        pc_sel,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Wait counter only needs to reach TIMEOUT; the FSM leaves MEM_WAIT there.
  localparam int              WAIT_W   = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              freeze;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_wr_reg  (ex_wr_reg),
    .ex_mem2reg (ex_mem2reg),
    .ex_reg_wr  (ex_reg_wr),
    .load_use   (load_use)
  );

  // State register; reset always lands in RUN regardless of memory activity
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Wait counter: 1 on the edge entering MEM_WAIT, then counts each wait cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == RUN && state_nxt == MEM_WAIT) begin
      wait_cnt <= WAIT_W'(1);
    end else if (state == MEM_WAIT && state_nxt == MEM_WAIT) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Next state, memory freeze and the priority-ordered stage strobes
  always_comb begin
    state_nxt   = state;
    freeze      = 1'b0;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pc_sel      = PC_SEQ;
    halted      = 1'b0;

    case (state)
      RUN: begin
        // A same-cycle ready is a zero-wait access and never freezes
        if (dmem_req && !dmem_ready) begin
          freeze    = 1'b1;
          state_nxt = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        // Ready on the TIMEOUT cycle still completes the access
        if (dmem_ready) begin
          state_nxt = RUN;
        end else begin
          freeze = 1'b1;
          if (wait_cnt == WAIT_MAX) begin
            state_nxt = HALT;
          end
        end
      end
      HALT: begin
        freeze = 1'b1;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase

    if (rst) begin
      // Hold every stage and push NOPs into the front of the pipe
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (freeze) begin
      // Whole pipe holds; control hazards are re-evaluated on release
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      halted    = (state == HALT);
    end else if (ex_br_taken) begin
      // Taken branch squashes both younger instructions, overriding load-use
      pc_sel      = PC_BR;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (id_jmp) begin
      // Jump resolves in ID, so only the fetched slot is squashed
      pc_sel      = PC_JMP;
      if_id_flush = 1'b1;
    end else if (load_use) begin
      // Hold IF/ID, inject a single bubble into EX, let older stages drain
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Saturating performance counters for stalled-PC and flush cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (if_id_flush && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule
